// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM controller shared by the MEM-stage data port
// and the instruction-fetch port. Requests of 1/2/4 bytes are split into
// single-byte RAM beats. Read bytes are assembled into a little-endian word.
module mem_ctrl #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned IF_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [1:0]        mem_rw,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [2:0]        mem_times,
  output logic [31:0]       mem_rdata,
  output logic [1:0]        mem_status,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [31:0]       if_rdata,
  output logic [1:0]        if_status,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  typedef enum logic {OWN_MEM, OWN_IF} owner_t;
  typedef enum logic [1:0] {ST_INIT = 2'b00, ST_BUSY = 2'b01, ST_DONE = 2'b10} status_t;

  state_t              state_q, state_n;
  owner_t              own_q, own_n;
  logic [ADDR_W-1:0]   addr_q, addr_n;
  logic [31:0]         wdata_q, wdata_n;
  logic [2:0]          n_q, n_n;
  logic [2:0]          cnt_q, cnt_n;
  logic [31:0]         buf_q, buf_n;
  logic [ADDR_W-1:0]   ram_a_q, ram_a_n;
  logic [7:0]          ram_dout_q, ram_dout_n;
  logic                ram_wr_q, ram_wr_n;
  logic [31:0]         mem_rdata_q, mem_rdata_n;
  logic [31:0]         if_rdata_q, if_rdata_n;
  status_t             mem_st_q, mem_st_n;
  status_t             if_st_q, if_st_n;

  logic                mem_valid;
  logic                mem_is_wr;
  logic [2:0]          mem_n;
  logic [2:0]          cnt_p1;
  logic [4:0]          cap_pos;
  logic [4:0]          wr_pos;

  assign mem_rdata  = mem_rdata_q;
  assign mem_status = mem_st_q;
  assign if_rdata   = if_rdata_q;
  assign if_status  = if_st_q;
  assign ram_dout   = ram_dout_q;
  assign ram_a      = ram_a_q;
  assign ram_wr     = ram_wr_q;

  // Decode the MEM request and clamp its byte count.
  always_comb begin
    mem_valid = (mem_rw == 2'b01) || (mem_rw == 2'b10);
    mem_is_wr = (mem_rw == 2'b10);
    case (mem_times)
      3'd0:    mem_n = 3'd0;
      3'd1:    mem_n = 3'd1;
      3'd2:    mem_n = 3'd2;
      default: mem_n = 3'd4;
    endcase
    cnt_p1  = cnt_q + 3'd1;
    // Byte captured at this edge was issued two edges ago: index cnt-1.
    cap_pos = {cnt_q[1:0] - 2'd1, 3'b000};
    wr_pos  = {cnt_q[1:0] + 2'd1, 3'b000};
  end

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_n     = state_q;
    own_n       = own_q;
    addr_n      = addr_q;
    wdata_n     = wdata_q;
    n_n         = n_q;
    cnt_n       = cnt_q;
    buf_n       = buf_q;
    ram_a_n     = ram_a_q;
    ram_dout_n  = ram_dout_q;
    ram_wr_n    = ram_wr_q;
    mem_rdata_n = mem_rdata_q;
    if_rdata_n  = if_rdata_q;
    mem_st_n    = mem_st_q;
    if_st_n     = if_st_q;

    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          own_n   = OWN_MEM;
          addr_n  = mem_addr;
          wdata_n = mem_wdata;
          n_n     = mem_n;
          cnt_n   = 3'd0;
          buf_n   = '0;
          if (mem_n == 3'd0) begin
            state_n     = DONE;
            mem_st_n    = ST_DONE;
            mem_rdata_n = '0;
          end else begin
            mem_st_n = ST_BUSY;
            ram_a_n  = mem_addr;
            if (mem_is_wr) begin
              state_n    = WR;
              ram_dout_n = mem_wdata[7:0];
              ram_wr_n   = 1'b1;
            end else begin
              state_n  = RD;
              ram_wr_n = 1'b0;
            end
          end
        end else if (if_req && !if_flush) begin
          own_n    = OWN_IF;
          addr_n   = if_addr;
          n_n      = 3'(IF_BYTES);
          cnt_n    = 3'd0;
          buf_n    = '0;
          state_n  = RD;
          ram_a_n  = if_addr;
          ram_wr_n = 1'b0;
          if_st_n  = ST_BUSY;
        end
      end

      RD: begin
        if (own_q == OWN_IF && if_flush) begin
          state_n  = IDLE;
          if_st_n  = ST_INIT;
          ram_wr_n = 1'b0;
        end else begin
          cnt_n = cnt_p1;
          if (cnt_p1 < n_q)
            ram_a_n = addr_q + ADDR_W'(cnt_p1);
          if (cnt_q != 3'd0)
            buf_n[cap_pos +: 8] = ram_din;
          if (cnt_q == n_q) begin
            state_n = DONE;
            if (own_q == OWN_MEM) begin
              mem_st_n    = ST_DONE;
              mem_rdata_n = buf_n;
            end else begin
              if_st_n    = ST_DONE;
              if_rdata_n = buf_n;
            end
          end
        end
      end

      WR: begin
        cnt_n = cnt_p1;
        if (cnt_p1 < n_q) begin
          ram_a_n    = addr_q + ADDR_W'(cnt_p1);
          ram_dout_n = wdata_q[wr_pos +: 8];
          ram_wr_n   = 1'b1;
        end else begin
          ram_wr_n = 1'b0;
          state_n  = DONE;
          mem_st_n = ST_DONE;
        end
      end

      DONE: begin
        state_n  = IDLE;
        mem_st_n = ST_INIT;
        if_st_n  = ST_INIT;
      end

      default: state_n = IDLE;
    endcase
  end

  // State and output registers; rdy=0 freezes everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      own_q       <= OWN_MEM;
      addr_q      <= '0;
      wdata_q     <= '0;
      n_q         <= '0;
      cnt_q       <= '0;
      buf_q       <= '0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
      mem_rdata_q <= '0;
      if_rdata_q  <= '0;
      mem_st_q    <= ST_INIT;
      if_st_q     <= ST_INIT;
    end else if (rdy) begin
      state_q     <= state_n;
      own_q       <= own_n;
      addr_q      <= addr_n;
      wdata_q     <= wdata_n;
      n_q         <= n_n;
      cnt_q       <= cnt_n;
      buf_q       <= buf_n;
      ram_a_q     <= ram_a_n;
      ram_dout_q  <= ram_dout_n;
      ram_wr_q    <= ram_wr_n;
      mem_rdata_q <= mem_rdata_n;
      if_rdata_q  <= if_rdata_n;
      mem_st_q    <= mem_st_n;
      if_st_q     <= if_st_n;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed self-checking bench for mem_ctrl with a
// synchronous-read byte RAM model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [1:0]  mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_times;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_status;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic [31:0] if_rdata;
  logic [1:0]  if_status;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;

  logic [7:0]  ram [0:1023];

  int n_cmp = 0;
  int n_err = 0;

  mem_ctrl #(.ADDR_W(32), .IF_BYTES(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_times(mem_times), .mem_rdata(mem_rdata), .mem_status(mem_status),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_status(if_status),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
  );

  always #5 clk = ~clk;

  // RAM model: data for the address sampled at an edge appears after it.
  always @(posedge clk) begin
    if (ram_wr) ram[ram_a[9:0]] <= ram_dout;
    ram_din <= ram[ram_a[9:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h100] = 8'h11; ram[10'h101] = 8'h22; ram[10'h102] = 8'h33; ram[10'h103] = 8'h44;
    ram[10'h000] = 8'h13; ram[10'h001] = 8'h05; ram[10'h002] = 8'h10; ram[10'h003] = 8'h00;
    ram[10'h004] = 8'h78; ram[10'h005] = 8'h56; ram[10'h006] = 8'h34; ram[10'h007] = 8'h12;
    ram[10'h008] = 8'hEF; ram[10'h009] = 8'hBE; ram[10'h00A] = 8'hAD; ram[10'h00B] = 8'hDE;
    ram[10'h200] = 8'h5A;

    rst = 1'b0; rdy = 1'b1; mem_rw = 2'b00; mem_addr = '0; mem_wdata = '0;
    mem_times = 3'd0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_ram_a", ram_a, 32'h0);
    chk("rst_ram_wr", {31'd0, ram_wr}, 32'h0);
    chk("rst_ram_dout", {24'd0, ram_dout}, 32'h0);
    chk("rst_mem_status", {30'd0, mem_status}, 32'h0);
    chk("rst_if_status", {30'd0, if_status}, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    rst = 1'b1;
    tick();

    // LW 0x100
    mem_rw = 2'b01; mem_addr = 32'h100; mem_times = 3'd4;
    tick();
    chk("lw_e0_ram_a", ram_a, 32'h100);
    chk("lw_e0_status", {30'd0, mem_status}, 32'h1);
    chk("lw_e0_ram_wr", {31'd0, ram_wr}, 32'h0);
    mem_rw = 2'b00; mem_addr = 32'h3FC;
    tick(); chk("lw_e1_ram_a", ram_a, 32'h101);
    tick(); chk("lw_e2_ram_a", ram_a, 32'h102);
    tick(); chk("lw_e3_ram_a", ram_a, 32'h103);
    tick(); chk("lw_e4_status", {30'd0, mem_status}, 32'h1);
    tick();
    chk("lw_e5_status", {30'd0, mem_status}, 32'h2);
    chk("lw_e5_rdata", mem_rdata, 32'h44332211);
    tick();
    chk("lw_e6_status", {30'd0, mem_status}, 32'h0);
    chk("lw_e6_rdata_hold", mem_rdata, 32'h44332211);

    // SH 0x20
    mem_rw = 2'b10; mem_addr = 32'h20; mem_wdata = 32'hABCD1234; mem_times = 3'd2;
    tick();
    chk("sh_e0_ram_a", ram_a, 32'h20);
    chk("sh_e0_dout", {24'd0, ram_dout}, 32'h34);
    chk("sh_e0_wr", {31'd0, ram_wr}, 32'h1);
    mem_rw = 2'b00; mem_addr = 32'h300; mem_wdata = 32'h0; mem_times = 3'd4;
    tick();
    chk("sh_e1_ram_a", ram_a, 32'h21);
    chk("sh_e1_dout", {24'd0, ram_dout}, 32'h12);
    chk("sh_e1_wr", {31'd0, ram_wr}, 32'h1);
    chk("sh_e1_status", {30'd0, mem_status}, 32'h1);
    tick();
    chk("sh_e2_wr", {31'd0, ram_wr}, 32'h0);
    chk("sh_e2_status", {30'd0, mem_status}, 32'h2);
    chk("sh_ram20", {24'd0, ram[10'h020]}, 32'h34);
    chk("sh_ram21", {24'd0, ram[10'h021]}, 32'h12);
    chk("sh_ram22", {24'd0, ram[10'h022]}, 32'h00);
    tick();
    chk("sh_e3_status", {30'd0, mem_status}, 32'h0);

    // Zero-length MEM read: immediate DONE with zero data
    mem_rw = 2'b01; mem_addr = 32'h100; mem_times = 3'd0;
    tick();
    chk("z_e0_status", {30'd0, mem_status}, 32'h2);
    chk("z_e0_rdata", mem_rdata, 32'h0);
    mem_rw = 2'b00;
    tick();
    chk("z_e1_status", {30'd0, mem_status}, 32'h0);

    // Simultaneous MEM LB and IF fetch: MEM first
    mem_rw = 2'b01; mem_addr = 32'h100; mem_times = 3'd1;
    if_req = 1'b1; if_addr = 32'h4;
    tick();
    chk("arb_e0_mem", {30'd0, mem_status}, 32'h1);
    chk("arb_e0_if", {30'd0, if_status}, 32'h0);
    mem_rw = 2'b00;
    tick();
    chk("arb_e1_if", {30'd0, if_status}, 32'h0);
    tick();
    chk("arb_e2_mem", {30'd0, mem_status}, 32'h2);
    chk("arb_e2_rdata", mem_rdata, 32'h00000011);
    chk("arb_e2_if", {30'd0, if_status}, 32'h0);
    tick();
    chk("arb_e3_if", {30'd0, if_status}, 32'h0);
    tick();
    chk("arb_e4_if", {30'd0, if_status}, 32'h1);
    chk("arb_e4_ram_a", ram_a, 32'h4);
    if_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("arb_if_busy", {30'd0, if_status}, 32'h1);
    end
    tick();
    chk("arb_if_done", {30'd0, if_status}, 32'h2);
    chk("arb_if_rdata", if_rdata, 32'h12345678);
    tick();
    chk("arb_if_init", {30'd0, if_status}, 32'h0);

    // Fetch 0x0 flushed after E2
    if_req = 1'b1; if_addr = 32'h0;
    tick();
    chk("fl_e0_if", {30'd0, if_status}, 32'h1);
    if_req = 1'b0;
    tick(); tick();
    if_flush = 1'b1;
    tick();
    chk("fl_e3_if", {30'd0, if_status}, 32'h0);
    chk("fl_e3_rdata", if_rdata, 32'h12345678);
    if_flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fl_no_done", {30'd0, if_status}, 32'h0);
    end
    if_req = 1'b1; if_addr = 32'h8;
    tick();
    chk("f8_e0_if", {30'd0, if_status}, 32'h1);
    if_req = 1'b0;
    tick(); tick(); tick(); tick();
    tick();
    chk("f8_done", {30'd0, if_status}, 32'h2);
    chk("f8_rdata", if_rdata, 32'hDEADBEEF);
    tick();

    // LB 0x200 with a 3-cycle rdy freeze
    mem_rw = 2'b01; mem_addr = 32'h200; mem_times = 3'd1;
    tick();
    chk("lb_e0_ram_a", ram_a, 32'h200);
    mem_rw = 2'b00;
    tick();
    chk("lb_e1_status", {30'd0, mem_status}, 32'h1);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lb_frz_status", {30'd0, mem_status}, 32'h1);
      chk("lb_frz_ram_a", ram_a, 32'h200);
    end
    rdy = 1'b1;
    tick();
    chk("lb_done", {30'd0, mem_status}, 32'h2);
    chk("lb_rdata", mem_rdata, 32'h0000005A);
    tick();

    // Reset in the middle of a LW
    mem_rw = 2'b01; mem_addr = 32'h100; mem_times = 3'd4;
    tick();
    mem_rw = 2'b00;
    tick();
    chk("rl_e1_ram_a", ram_a, 32'h101);
    rst = 1'b0;
    tick(); tick();
    chk("rl_ram_a", ram_a, 32'h0);
    chk("rl_ram_wr", {31'd0, ram_wr}, 32'h0);
    chk("rl_mem_status", {30'd0, mem_status}, 32'h0);
    chk("rl_if_status", {30'd0, if_status}, 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rl_quiet_ram_a", ram_a, 32'h0);
      chk("rl_quiet_status", {30'd0, mem_status}, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
